// File: rtl/spi_arbiter.sv
// spi_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one byte-oriented
//   SPI master. A requester keeps ownership for a whole burst, which ends on
//   the byte marked req_last. The owner's SPI mode (cpol/cpha) is latched at
//   grant time and held stable until the grant drops.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   When defined, a watchdog releases the grant if WAIT sees no m_rx_valid,
//   or HOLD sees no owner request, for TIMEOUT_CYCLES cycles. timeout_err
//   then pulses for one cycle. When undefined, timeout_err is tied low and
//   WAIT/HOLD wait indefinitely.
//
// Ports
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   req_valid/data/last        per-requester byte stream (data at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_cpol, req_cpha         per-requester SPI mode
//   req_ready                  byte accepted, one-hot to the owner or zero
//   rsp_data, rsp_valid        received byte (shared) and one-cycle pulse to its owner
//   grant                      one-hot current owner, zero when idle
//   m_tx_data/valid/ready      byte handshake towards the SPI master
//   m_rx_data/valid            received byte from the SPI master
//   m_cpol, m_cpha             SPI mode towards the SPI master
//   timeout_err                one-cycle watchdog pulse

module spi_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_cpol,
  input  logic [NUM_REQ-1:0]            req_cpha,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         m_tx_data,
  output logic                          m_tx_valid,
  input  logic                          m_tx_ready,
  input  logic [DATA_WIDTH-1:0]         m_rx_data,
  input  logic                          m_rx_valid,
  output logic                          m_cpol,
  output logic                          m_cpha,
  output logic                          timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic               last_q;

  logic               any_req;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   next_ptr;
  logic               handshake;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Search upward from rr_ptr with wrap; the first asserted request wins.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        any_req = 1'b1;
        winner  = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // Pointer value after the current owner finishes, wrapping to zero.
  always_comb begin
    if (int'(owner) == NUM_REQ - 1) next_ptr = '0;
    else                            next_ptr = owner + 1'b1;
  end

  // The owner's byte is forwarded combinationally so a request seen in the
  // grant cycle can be offered to the master without an extra register stage.
  always_comb begin
    m_tx_valid = (state == ISSUE) && req_valid[owner];
    m_tx_data  = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    handshake  = m_tx_valid && m_tx_ready;
    req_ready  = handshake ? onehot(owner) : '0;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog;
  // Expiry fires when the counter has spent TIMEOUT_CYCLES cycles in the
  // state, so the pulse lands exactly TIMEOUT_CYCLES cycles after entry.
  logic              wdog_expired;
  assign wdog_expired = (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM; all registered outputs are updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      last_q    <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      m_cpol    <= 1'b0;
      m_cpha    <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
      wdog        <= '0;
`endif
    end else begin
      rsp_valid <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            owner  <= winner;
            grant  <= onehot(winner);
            m_cpol <= req_cpol[winner];
            m_cpha <= req_cpha[winner];
            state  <= ISSUE;
          end
        end

        ISSUE: begin
          if (handshake) begin
            last_q <= req_last[owner];
            state  <= WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            wdog   <= '0;
`endif
          end
        end

        WAIT: begin
          if (m_rx_valid) begin
            rsp_data  <= m_rx_data;
            rsp_valid <= onehot(owner);
            if (last_q) begin
              state  <= IDLE;
              grant  <= '0;
              rr_ptr <= next_ptr;
            end else begin
              state  <= HOLD;
`ifdef SPI_ARB_TIMEOUT_EN
              wdog   <= '0;
`endif
            end
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (wdog_expired) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= next_ptr;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end

        HOLD: begin
          // Only the owner can continue; other requesters are ignored here.
          if (req_valid[owner]) begin
            state <= ISSUE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (wdog_expired) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= next_ptr;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end

        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter
//   Directed self-checking bench for spi_arbiter (NUM_REQ=4, DATA_WIDTH=8,
//   TIMEOUT_CYCLES=16). The SPI master is modelled by driving m_tx_ready,
//   m_rx_valid and m_rx_data directly. Watchdog behaviour is checked in both
//   builds of SPI_ARB_TIMEOUT_EN.

module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_cpol;
  logic [3:0]  req_cpha;
  logic [3:0]  req_ready;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_valid;
  logic [3:0]  grant;
  logic [7:0]  m_tx_data;
  logic        m_tx_valid;
  logic        m_tx_ready;
  logic [7:0]  m_rx_data;
  logic        m_rx_valid;
  logic        m_cpol;
  logic        m_cpha;
  logic        timeout_err;

  int checkCount = 0;
  int failCount  = 0;

  spi_arbiter #(
    .DATA_WIDTH(8),
    .NUM_REQ(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_cpol(req_cpol),
    .req_cpha(req_cpha),
    .req_ready(req_ready),
    .rsp_data(rsp_data),
    .rsp_valid(rsp_valid),
    .grant(grant),
    .m_tx_data(m_tx_data),
    .m_tx_valid(m_tx_valid),
    .m_tx_ready(m_tx_ready),
    .m_rx_data(m_rx_data),
    .m_rx_valid(m_rx_valid),
    .m_cpol(m_cpol),
    .m_cpha(m_cpha),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Counts every comparison and reports any mismatch on one line.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Advance one cycle and sample away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                               input logic [3:0] cpol, input logic [3:0] cpha);
    req_valid = valid;
    req_last  = last;
    req_cpol  = cpol;
    req_cpha  = cpha;
  endtask

  task automatic setData(input int idx, input logic [7:0] value);
    req_data[idx*8 +: 8] = value;
  endtask

  task automatic applyReset();
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    req_cpol   = '0;
    req_cpha   = '0;
    m_tx_ready = 1'b1;
    m_rx_valid = 1'b0;
    m_rx_data  = '0;
    tick();
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_tx_valid", 32'(m_tx_valid), 32'h0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'h0);
    checkOutput("rst_mode", 32'({m_cpol, m_cpha}), 32'h0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'h0);
    tick();
    rst = 1'b0;
  endtask

  // Serve one byte with m_tx_ready high: wait (bounded) for the offer, check
  // the ISSUE cycle, the WAIT cycle and the response pulse.
  task automatic serveOne(input string tag, input logic [3:0] expGrant, input logic [1:0] expMode,
                          input logic [7:0] expTx, input logic [7:0] rxByte);
    int waited = 0;
    #1;
    while (!m_tx_valid && waited < 8) begin
      tick();
      waited++;
    end
    if (!m_tx_valid) begin
      checkOutput({tag, "_tx_wait"}, 32'(m_tx_valid), 32'h1);
      return;
    end
    checkOutput({tag, "_grant"}, 32'(grant), 32'(expGrant));
    checkOutput({tag, "_tx_data"}, 32'(m_tx_data), 32'(expTx));
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(expGrant));
    checkOutput({tag, "_mode"}, 32'({m_cpol, m_cpha}), 32'(expMode));
    tick();
    checkOutput({tag, "_wait_tx_valid"}, 32'(m_tx_valid), 32'h0);
    checkOutput({tag, "_wait_ready"}, 32'(req_ready), 32'h0);
    checkOutput({tag, "_wait_grant"}, 32'(grant), 32'(expGrant));
    checkOutput({tag, "_wait_mode"}, 32'({m_cpol, m_cpha}), 32'(expMode));
    m_rx_valid = 1'b1;
    m_rx_data  = rxByte;
    tick();
    m_rx_valid = 1'b0;
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(expGrant));
    checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'(rxByte));
  endtask

  initial begin
    // Single byte from requester 0, master loops the byte back.
    applyReset();
    setData(0, 8'hA5);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    #1;
    checkOutput("single_idle_tx_valid", 32'(m_tx_valid), 32'h0);
    serveOne("single", 4'b0001, 2'b00, 8'hA5, 8'hA5);
    checkOutput("single_grant_after", 32'(grant), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("single_rsp_pulse_end", 32'(rsp_valid), 32'h0);

    // Contention: all four request continuously with single-byte bursts.
    applyReset();
    for (int i = 0; i < 4; i++) setData(i, 8'h10 + 8'(i));
    applyStimulus(4'b1111, 4'b1111, 4'b0000, 4'b0000);
    serveOne("rr0", 4'b0001, 2'b00, 8'h10, 8'hC0);
    serveOne("rr1", 4'b0010, 2'b00, 8'h11, 8'hC1);
    serveOne("rr2", 4'b0100, 2'b00, 8'h12, 8'hC2);
    serveOne("rr3", 4'b1000, 2'b00, 8'h13, 8'hC3);
    serveOne("rr4", 4'b0001, 2'b00, 8'h10, 8'hC4);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Burst from requester 2 with requester 1 waiting; no pre-emption.
    applyReset();
    setData(1, 8'h44);
    setData(2, 8'h11);
    applyStimulus(4'b0100, 4'b0010, 4'b0000, 4'b0000);
    serveOne("burst_b0", 4'b0100, 2'b00, 8'h11, 8'h81);
    setData(2, 8'h22);
    applyStimulus(4'b0110, 4'b0010, 4'b0000, 4'b0000);
    serveOne("burst_b1", 4'b0100, 2'b00, 8'h22, 8'h82);
    setData(2, 8'h33);
    applyStimulus(4'b0110, 4'b0110, 4'b0000, 4'b0000);
    serveOne("burst_b2", 4'b0100, 2'b00, 8'h33, 8'h83);
    checkOutput("burst_release", 32'(grant), 32'h0);
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 4'b0000);
    serveOne("burst_next", 4'b0010, 2'b00, 8'h44, 8'h84);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Per-requester SPI mode: req1 mode 1/1, req3 mode 0/1.
    applyReset();
    setData(1, 8'h5C);
    setData(3, 8'h3E);
    applyStimulus(4'b1010, 4'b1010, 4'b0010, 4'b1010);
    serveOne("mode_r1", 4'b0010, 2'b11, 8'h5C, 8'h01);
    checkOutput("mode_idle_hold", 32'({m_cpol, m_cpha}), 32'h3);
    serveOne("mode_r3", 4'b1000, 2'b01, 8'h3E, 8'h02);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("mode_idle_hold2", 32'({m_cpol, m_cpha}), 32'h1);

    // Reset asserted for one cycle while waiting for the received byte.
    applyReset();
    setData(0, 8'h5A);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tick();
    tick();
    checkOutput("rstw_pre_grant", 32'(grant), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstw_grant", 32'(grant), 32'h0);
    checkOutput("rstw_tx_valid", 32'(m_tx_valid), 32'h0);
    m_rx_valid = 1'b1;
    m_rx_data  = 8'hEE;
    tick();
    m_rx_valid = 1'b0;
    checkOutput("rstw_late_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rstw_late_rsp_data", 32'(rsp_data), 32'h0);

    // Master never returns a byte; requester 1 waits behind requester 0.
    applyReset();
    setData(0, 8'h77);
    setData(1, 8'h66);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tick();
    tick();
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 4'b0000);
`ifdef SPI_ARB_TIMEOUT_EN
    repeat (15) tick();
    checkOutput("wd_before", 32'(timeout_err), 32'h0);
    checkOutput("wd_before_grant", 32'(grant), 32'h1);
    tick();
    checkOutput("wd_pulse", 32'(timeout_err), 32'h1);
    checkOutput("wd_grant", 32'(grant), 32'h0);
    checkOutput("wd_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    checkOutput("wd_pulse_end", 32'(timeout_err), 32'h0);
    checkOutput("wd_next_grant", 32'(grant), 32'h2);
`else
    repeat (20) tick();
    checkOutput("nowd_timeout", 32'(timeout_err), 32'h0);
    checkOutput("nowd_grant", 32'(grant), 32'h1);
    checkOutput("nowd_tx_valid", 32'(m_tx_valid), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, byte width; NUM_REQ, 4, number of requesters; TIMEOUT_CYCLES, 1024, watchdog limit (used only with SPI_ARB_TIMEOUT_EN).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  byte is last of burst
- req_cpol, req_cpha  in  NUM_REQ each  per-requester SPI mode
- req_ready  out  NUM_REQ  byte accepted (one-hot or zero)
- rsp_data  out  DATA_WIDTH  received byte, shared
- rsp_valid  out  NUM_REQ  one-cycle pulse to owner of rsp_data
- grant  out  NUM_REQ  one-hot current owner, zero when idle
- m_tx_data  out  DATA_WIDTH  to SPI master tx_data
- m_tx_valid  out  1  to SPI master tx_valid
- m_tx_ready  in  1  from SPI master tx_ready
- m_rx_data  in  DATA_WIDTH  from SPI master rx_data
- m_rx_valid  in  1  from SPI master rx_valid
- m_cpol, m_cpha  out  1 each  to SPI master cpol/cpha
- timeout_err  out  1  one-cycle watchdog pulse

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-004 IDLE: if any req_valid, winner = first asserted index searching upward from rr_ptr with wrap; next cycle grant = one-hot(winner), state ISSUE; winner's req_cpol/req_cpha latched into m_cpol/m_cpha.
REQ-005 m_cpol/m_cpha SHALL stay constant from grant until grant drops; in IDLE they SHALL hold their last value.
REQ-006 ISSUE: m_tx_valid = req_valid[owner], m_tx_data = owner's req_data (combinational); req_ready[owner] = m_tx_valid & m_tx_ready; on that handshake, latch req_last[owner] as last_q and go WAIT.
REQ-007 m_tx_valid and req_ready SHALL be 0 in IDLE, WAIT, HOLD.
REQ-008 WAIT: on m_rx_valid, rsp_data <= m_rx_data and rsp_valid[owner] pulses next cycle; then IDLE if last_q, else HOLD.
REQ-009 HOLD: grant kept; when req_valid[owner] go ISSUE next cycle; other requesters SHALL NOT be granted.
REQ-010 On return to IDLE after last byte, rr_ptr <= (owner+1) mod NUM_REQ and grant <= 0; requests are evaluated in IDLE no earlier than the following cycle.
REQ-011 Latency: request seen in IDLE at cycle N -> grant at N+1 -> earliest m_tx_valid at N+1; m_rx_valid at cycle M -> rsp_valid at M+1.
REQ-012 m_rx_valid outside WAIT SHALL be ignored.
REQ-013 Simultaneous requests SHALL resolve by round-robin only; each requester waits at most NUM_REQ-1 bursts.
REQ-014 Requests from non-owners SHALL not affect owner's burst; no pre-emption.
REQ-015 rr_ptr SHALL be $clog2(NUM_REQ) bits, wrapping NUM_REQ-1 -> 0.

Reset
REQ-016 On rst: state IDLE, grant 0, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_data 0, m_tx_valid 0, m_cpol 0, m_cpha 0, timeout_err 0, watchdog 0, last_q 0.
REQ-017 rst asserted mid-burst SHALL drop m_tx_valid and grant in the cycle after rst is sampled; any in-flight m_rx_valid SHALL be discarded.

Configuration
REQ-018 Macro SPI_ARB_TIMEOUT_EN SHALL gate the watchdog.
REQ-019 Defined: counter clears on entry to WAIT or HOLD and increments each cycle there; on reaching TIMEOUT_CYCLES with no m_rx_valid (WAIT) or req_valid[owner] (HOLD), timeout_err pulses one cycle, no rsp_valid, grant released, rr_ptr advanced as in REQ-010, state IDLE.
REQ-020 Not defined: no counter logic; timeout_err tied 0; WAIT and HOLD wait indefinitely.

Verification
REQ-021 Single byte: req0 sends 0xA5 last=1, master loops MISO -> rsp_valid=0001, rsp_data=0xA5, grant 0 afterward.
REQ-022 Contention: req_valid=1111 continuous, single-byte bursts -> grants in order 0,1,2,3,0.
REQ-023 Burst: req2 sends 0x11,0x22,0x33 (last on 0x33), req1 also requesting -> grant stays 0100 for all three bytes, then 0010.
REQ-024 Mode: req1 cpol=1,cpha=1, req3 cpol=0,cpha=1 -> m_cpol/m_cpha = 1/1 during req1 grant, 0/1 during req3 grant, stable within each.
REQ-025 Reset mid-WAIT: rst high one cycle -> next cycle grant=0, m_tx_valid=0; late m_rx_valid produces no rsp_valid.
REQ-026 With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, m_rx_valid never asserted -> timeout_err pulses 16 cycles after WAIT entry, grant 0, next requester served.
